// File: rtl/fetch_queue.sv
// Fetch buffer between IF and ID: captures the ROM word for last cycle's fetch,
// tags it with its PC and queues it for decode; stalls IF and flushes on jumps.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     jump,
  input  logic [31:0]              i_addr,
  input  logic [31:0]              i_data,
  output logic                     stall,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic            req_v_q, req_v_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [AW+1:0]   demand;
  logic            push;
  logic            pop;

  // Each entry is {pc, instr}
  logic [63:0]     mem [DEPTH];

  always_comb begin
    // Entries held plus the word still in flight; pop is deliberately ignored
    demand    = {1'b0, count_q} + {{(AW+1){1'b0}}, req_v_q};
    stall     = !jump && (demand >= (AW+2)'(DEPTH));
    out_valid = (count_q != '0) && !jump;
    push      = req_v_q && !jump;
    pop       = out_valid && out_ready;

    req_v_d   = !stall;
    req_pc_d  = stall ? req_pc_q : i_addr;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (jump) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_v_q  <= 1'b0;
      req_pc_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      req_v_q  <= req_v_d;
      req_pc_q <= req_pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {req_pc_q, i_data};
  end

  assign {out_pc, out_instr} = mem[rd_ptr_q];
  assign occupancy           = count_q;

endmodule
